// File: rtl/sv_uart_tx_fifo_if.sv
// AXI-stream style byte channel shared by the FIFO write and read sides.
interface sv_uart_tx_fifo_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sv_uart_tx_fifo.sv
// Elastic byte buffer feeding the UART transmitter's stream port.
// Optional inter-word output gap enabled by defining SV_UART_TX_FIFO_GAP_EN.
module sv_uart_tx_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  iclk,
   input  logic                  irst,
   input  logic                  iflush,
   sv_uart_tx_fifo_if.slave      s_axis,
   sv_uart_tx_fifo_if.master     m_axis,
   input  logic [15:0]           igap,
   output logic [DEPTH_LOG2:0]   olevel,
   output logic                  oempty,
   output logic                  ofull
);
   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned PW    = DEPTH_LOG2 + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [PW-1:0]         wr_ptr_nxt, rd_ptr_nxt, level_nxt;
   logic                  s_ready_q, m_valid_q;
   logic                  wr_en, rd_en;
   logic                  gap_idle_nxt;

   assign s_axis.tready = s_ready_q;
   assign m_axis.tvalid = m_valid_q;
   assign m_axis.tdata  = mem[rd_ptr[DEPTH_LOG2-1:0]];

   // A flush cycle swallows both handshakes.
   assign wr_en = s_axis.tvalid && s_ready_q && !iflush;
   assign rd_en = m_valid_q && m_axis.tready && !iflush;

   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      if (iflush) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
      end else begin
         if (wr_en) wr_ptr_nxt = wr_ptr + PW'(1);
         if (rd_en) rd_ptr_nxt = rd_ptr + PW'(1);
      end
      level_nxt = wr_ptr_nxt - rd_ptr_nxt;
   end

`ifdef SV_UART_TX_FIFO_GAP_EN
   logic [15:0] gap_cnt, gap_nxt;

   // Reload on each output transfer, count down to zero otherwise.
   always_comb begin
      gap_nxt = gap_cnt;
      if (iflush)               gap_nxt = '0;
      else if (rd_en)           gap_nxt = igap;
      else if (gap_cnt != '0)   gap_nxt = gap_cnt - 16'(1);
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) gap_cnt <= '0;
      else      gap_cnt <= gap_nxt;
   end

   assign gap_idle_nxt = (gap_nxt == '0);
`else
   logic [15:0] unused_igap;
   assign unused_igap  = igap;
   assign gap_idle_nxt = 1'b1;
`endif

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         olevel    <= '0;
         oempty    <= 1'b1;
         ofull     <= 1'b0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         olevel    <= level_nxt;
         oempty    <= (level_nxt == '0);
         ofull     <= (level_nxt == PW'(DEPTH));
         s_ready_q <= (level_nxt < PW'(DEPTH)) && !iflush;
         m_valid_q <= (level_nxt != '0) && gap_idle_nxt;
      end
   end

   // Storage holds no reset; contents are only meaningful below the level.
   always_ff @(posedge iclk) begin
      if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= s_axis.tdata;
   end
endmodule

// File: tb/tb_sv_uart_tx_fifo.sv
// Scoreboard bench for sv_uart_tx_fifo: cycle model of level/flags plus an output-order queue.
module tb_sv_uart_tx_fifo;
   localparam int unsigned DW    = 8;
   localparam int unsigned DL2   = 4;
   localparam int          DEPTH = 16;

   logic          iclk = 1'b0;
   logic          irst = 1'b1;
   logic          iflush = 1'b0;
   logic [15:0]   igap = '0;
   logic [DL2:0]  olevel;
   logic          oempty, ofull;

   sv_uart_tx_fifo_if #(.DATA_WIDTH(DW)) s_axis ();
   sv_uart_tx_fifo_if #(.DATA_WIDTH(DW)) m_axis ();

   sv_uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
      .iclk   (iclk),
      .irst   (irst),
      .iflush (iflush),
      .s_axis (s_axis),
      .m_axis (m_axis),
      .igap   (igap),
      .olevel (olevel),
      .oempty (oempty),
      .ofull  (ofull)
   );

   always #5 iclk = ~iclk;

   int          checks = 0;
   int          errors = 0;
   logic [DW-1:0] exp_q[$];

   // Model state describes the DUT after the most recent rising edge.
   int  mlevel = 0;
   int  mgap   = 0;
   bit  mtready = 1'b0;
   bit  mtvalid = 1'b0;
   bit  m_wr, m_rd;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: compare current flags, then advance across the next edge.
   always @(negedge iclk) begin
      if (irst) begin
         mlevel = 0; mgap = 0; mtready = 1'b0; mtvalid = 1'b0;
         exp_q.delete();
      end else begin
         chk("s_tready", int'(s_axis.tready), int'(mtready));
         chk("m_tvalid", int'(m_axis.tvalid), int'(mtvalid));
         chk("olevel",   int'(olevel),        mlevel);
         chk("oempty",   int'(oempty),        int'(mlevel == 0));
         chk("ofull",    int'(ofull),         int'(mlevel == DEPTH));
         m_wr = s_axis.tvalid && mtready && !iflush;
         m_rd = mtvalid && m_axis.tready && !iflush;
         if (iflush) begin
            mlevel = 0; mgap = 0;
            exp_q.delete();
         end else begin
            if (m_wr) exp_q.push_back(s_axis.tdata);
            mlevel = mlevel + int'(m_wr) - int'(m_rd);
`ifdef SV_UART_TX_FIFO_GAP_EN
            if (m_rd)            mgap = int'(igap);
            else if (mgap != 0)  mgap = mgap - 1;
`endif
         end
         mtready = (mlevel < DEPTH) && !iflush;
         mtvalid = (mlevel != 0) && (mgap == 0);
      end
   end

   // Output monitor: every transfer must match the oldest accepted word.
   always @(negedge iclk) begin
      if (!irst && !iflush && m_axis.tvalid && m_axis.tready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL m_tdata: transfer of %0h with nothing expected at %0t", m_axis.tdata, $time);
         end else if (m_axis.tdata !== exp_q[0]) begin
            errors++;
            $display("FAIL m_tdata: got %0h expected %0h at %0t", m_axis.tdata, exp_q[0], $time);
            void'(exp_q.pop_front());
         end else begin
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic cyc(input bit wv, input logic [DW-1:0] d, input bit rr, input bit fl);
      @(posedge iclk);
      #2;
      s_axis.tvalid = wv;
      s_axis.tdata  = d;
      m_axis.tready = rr;
      iflush        = fl;
   endtask

   initial begin
      int n;
      s_axis.tvalid = 1'b0;
      s_axis.tdata  = '0;
      m_axis.tready = 1'b0;
      repeat (3) @(posedge iclk);
      #2 irst = 1'b0;
      @(negedge iclk);
      chk("rst_tready", int'(s_axis.tready), 0);
      chk("rst_level",  int'(olevel), 0);
      cyc(0, '0, 0, 0);
      @(negedge iclk);
      chk("idle_tready", int'(s_axis.tready), 1);
      chk("idle_tvalid", int'(m_axis.tvalid), 0);
      chk("idle_empty",  int'(oempty), 1);

      // Fill to full with the consumer stalled.
      for (int i = 0; i < DEPTH; i++) cyc(1, DW'(i), 0, 0);
      cyc(0, '0, 0, 0);
      @(negedge iclk);
      chk("fill_level", int'(olevel), 16);
      chk("fill_full",  int'(ofull), 1);
      chk("fill_tready", int'(s_axis.tready), 0);

      // Read from full while a write is offered: write must be refused.
      cyc(1, 8'hAA, 1, 0);
      cyc(0, '0, 0, 0);
      @(negedge iclk);
      chk("full_rd_level",  int'(olevel), 15);
      chk("full_rd_tready", int'(s_axis.tready), 1);
      for (int i = 0; i < 16; i++) cyc(0, '0, 1, 0);
      @(negedge iclk);
      chk("drain_empty", int'(oempty), 1);

      // Random concurrent traffic through pointer wrap.
      n = 0;
      for (int c = 0; c < 400 && n < 40; c++) begin
         cyc(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 2) == 0), 0);
         if (s_axis.tvalid && mtready) n++;
      end
      chk("rand_words", n, 40);
      for (int i = 0; i < 20; i++) cyc(0, '0, 1, 0);

      // Flush with both handshakes offered.
      for (int i = 0; i < 5; i++) cyc(1, DW'(8'h50 + i), 0, 0);
      cyc(1, 8'h99, 1, 1);
      cyc(0, '0, 0, 0);
      @(negedge iclk);
      chk("flush_level",  int'(olevel), 0);
      chk("flush_tvalid", int'(m_axis.tvalid), 0);
      chk("flush_tready", int'(s_axis.tready), 0);
      cyc(1, 8'h77, 0, 0);
      cyc(0, '0, 1, 0);
      cyc(0, '0, 1, 0);
      @(negedge iclk);
      chk("post_flush_empty", int'(oempty), 1);

`ifdef SV_UART_TX_FIFO_GAP_EN
      igap = 16'd3;
      for (int i = 0; i < 4; i++) cyc(1, DW'(8'hC0 + i), 0, 0);
      n = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(0, '0, 1, 0);
         @(negedge iclk);
         if (m_axis.tvalid) n++;
      end
      chk("gap3_xfers", n, 4);
      igap = 16'd0;
      for (int i = 0; i < 4; i++) cyc(1, DW'(8'hD0 + i), 0, 0);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(0, '0, 1, 0);
         @(negedge iclk);
         if (m_axis.tvalid) n++;
      end
      chk("gap0_xfers", n, 4);
`endif

      // Asynchronous reset with words in flight.
      for (int i = 0; i < 3; i++) cyc(1, DW'(8'hE0 + i), 0, 0);
      cyc(0, '0, 0, 0);
      @(posedge iclk);
      #3 irst = 1'b1;
      #1;
      chk("arst_level",  int'(olevel), 0);
      chk("arst_tvalid", int'(m_axis.tvalid), 0);
      chk("arst_tready", int'(s_axis.tready), 0);
      @(posedge iclk);
      #2 irst = 1'b0;
      cyc(1, 8'h3C, 0, 0);
      cyc(0, '0, 1, 0);
      cyc(0, '0, 1, 0);
      @(negedge iclk);
      chk("end_empty", int'(oempty), 1);
      chk("end_queue", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish by %0t", $time);
      $fatal(1, "timeout");
   end
endmodule
